// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one memory port between instruction fetch (imem) and the LSU (dmem).
// Data accesses win contention, except when fetch has already watched
// STARVE_LIMIT consecutive data grants go by; then fetch is picked once.
// The chosen requester stays locked onto the memory port until its grant
// (or until it aborts), so the memory sees stable request fields.
// The request and response paths are purely combinational.
module core_mem_arbiter #(
  parameter int MEM_ADDR_W   = 64,
  parameter int MEM_DATA_W   = 64,
  parameter int MEM_STRB_W   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  // fetch requester
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  // data requester
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  // shared memory port
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  // streak counts 0..STARVE_LIMIT inclusive
  localparam int            SW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_V = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  owner_t        owner;
  owner_t        owner_nxt;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic          sel_imem;
  logic          sel_dmem;
  logic          fetch_done;
  logic          data_done;

  // Pick which requester drives the memory port this cycle.
  // A locked owner is followed alone: if it drops its request the port goes
  // idle for that cycle (abort) and the other requester waits for NONE.
  always_comb begin
    sel_imem = 1'b0;
    sel_dmem = 1'b0;
    if (g_resetn) begin
      unique case (owner)
        OWN_IMEM: sel_imem = imem_req;
        OWN_DMEM: sel_dmem = dmem_req;
        default: begin
          if (imem_req && dmem_req) begin
            if (streak == LIMIT_V) sel_imem = 1'b1;
            else                   sel_dmem = 1'b1;
          end else begin
            sel_imem = imem_req;
            sel_dmem = dmem_req;
          end
        end
      endcase
    end
  end

  // A transaction completes in any cycle the selected requester sees mem_gnt.
  always_comb begin
    fetch_done = sel_imem && mem_gnt;
    data_done  = sel_dmem && mem_gnt;
  end

  // Ownership next state: lock only while a selected request is still
  // waiting; a grant or an abort always returns to NONE so the next cycle
  // re-arbitrates with the updated streak.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (sel_imem && !mem_gnt) begin
      owner_nxt = OWN_IMEM;
    end else if (sel_dmem && !mem_gnt) begin
      owner_nxt = OWN_DMEM;
    end
  end

  // Starvation counter: only meaningful while fetch is actually waiting.
  always_comb begin
    streak_nxt = streak;
    if (!imem_req) begin
      streak_nxt = '0;
    end else if (fetch_done) begin
      streak_nxt = '0;
    end else if (data_done && (streak != LIMIT_V)) begin
      streak_nxt = streak + SW'(1);
    end
  end

  // Ownership and streak registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      owner  <= OWN_NONE;
      streak <= '0;
    end else begin
      owner  <= owner_nxt;
      streak <= streak_nxt;
    end
  end

  // Forward the selected request; fetch never writes, idle drives zeros.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_strb  = '0;
    mem_wdata = '0;
    if (sel_imem) begin
      mem_req  = 1'b1;
      mem_addr = imem_addr;
    end else if (sel_dmem) begin
      mem_req   = 1'b1;
      mem_addr  = dmem_addr;
      mem_wen   = dmem_wen;
      mem_strb  = dmem_strb;
      mem_wdata = dmem_wdata;
    end
  end

  // Route the response back: gnt/err only to the selected port, read data
  // broadcast to both, everything held at zero during reset.
  always_comb begin
    imem_gnt   = sel_imem && mem_gnt;
    imem_err   = sel_imem && mem_err;
    dmem_gnt   = sel_dmem && mem_gnt;
    dmem_err   = sel_dmem && mem_err;
    imem_rdata = '0;
    dmem_rdata = '0;
    if (g_resetn) begin
      imem_rdata = mem_rdata;
      dmem_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios followed by a randomized
// phase, all compared each cycle against a behavioural arbitration model.
module tb_core_mem_arbiter;

  localparam int AW     = 64;
  localparam int DW     = 64;
  localparam int SW     = 8;
  localparam int STARVE = 4;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt, imem_err;
  logic [DW-1:0] imem_rdata;
  logic          dmem_req;
  logic [AW-1:0] dmem_addr;
  logic          dmem_wen;
  logic [SW-1:0] dmem_strb;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt, dmem_err;
  logic [DW-1:0] dmem_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_err;
  logic [DW-1:0] mem_rdata;

  // second instance with STARVE_LIMIT=1 shares the inputs
  logic          u1_imem_gnt, u1_imem_err, u1_dmem_gnt, u1_dmem_err;
  logic [DW-1:0] u1_imem_rdata, u1_dmem_rdata, u1_mem_wdata;
  logic          u1_mem_req, u1_mem_wen;
  logic [AW-1:0] u1_mem_addr;
  logic [SW-1:0] u1_mem_strb;

  core_mem_arbiter #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW), .STARVE_LIMIT(STARVE)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_err(imem_err),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  core_mem_arbiter #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW), .STARVE_LIMIT(1)) dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(u1_imem_gnt), .imem_err(u1_imem_err),
    .imem_rdata(u1_imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(u1_dmem_gnt), .dmem_err(u1_dmem_err),
    .dmem_rdata(u1_dmem_rdata),
    .mem_req(u1_mem_req), .mem_addr(u1_mem_addr), .mem_wen(u1_mem_wen), .mem_strb(u1_mem_strb),
    .mem_wdata(u1_mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  always #5 g_clk = ~g_clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: who holds the port (0 none, 1 fetch, 2 data) and streak
  int m_owner = 0;
  int m_streak = 0;
  logic e_igt, e_dgt;

  // snapshots of DUT outputs taken at the last check point
  logic          o_mreq, o_wen, o_igt, o_dgt, o_ierr, o_derr, o_u1_igt, o_u1_dgt;
  logic [AW-1:0] o_addr;
  logic [SW-1:0] o_strb;
  logic [DW-1:0] o_wdata, o_irdata, o_drdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set just after the previous edge; compare all
  // outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cyc();
    int who;
    int n_owner;
    int n_streak;
    #2;
    who = 0;
    if (g_resetn) begin
      if (m_owner == 1)                  who = imem_req ? 1 : 0;
      else if (m_owner == 2)             who = dmem_req ? 2 : 0;
      else if (imem_req && dmem_req)     who = (m_streak == STARVE) ? 1 : 2;
      else if (imem_req)                 who = 1;
      else if (dmem_req)                 who = 2;
    end
    e_igt = (who == 1) && mem_gnt;
    e_dgt = (who == 2) && mem_gnt;
    o_mreq = mem_req; o_addr = mem_addr; o_wen = mem_wen; o_strb = mem_strb;
    o_wdata = mem_wdata; o_igt = imem_gnt; o_dgt = dmem_gnt; o_ierr = imem_err;
    o_derr = dmem_err; o_irdata = imem_rdata; o_drdata = dmem_rdata;
    o_u1_igt = u1_imem_gnt; o_u1_dgt = u1_dmem_gnt;
    chk("mem_req",   64'(mem_req),   64'(who != 0));
    chk("mem_addr",  mem_addr,       (who == 1) ? imem_addr : (who == 2) ? dmem_addr : 64'd0);
    chk("mem_wen",   64'(mem_wen),   64'((who == 2) && dmem_wen));
    chk("mem_strb",  64'(mem_strb),  (who == 2) ? 64'(dmem_strb) : 64'd0);
    chk("mem_wdata", mem_wdata,      (who == 2) ? dmem_wdata : 64'd0);
    chk("imem_gnt",  64'(imem_gnt),  64'(e_igt));
    chk("dmem_gnt",  64'(dmem_gnt),  64'(e_dgt));
    chk("imem_err",  64'(imem_err),  64'((who == 1) && mem_err));
    chk("dmem_err",  64'(dmem_err),  64'((who == 2) && mem_err));
    chk("imem_rdata", imem_rdata,    g_resetn ? mem_rdata : 64'd0);
    chk("dmem_rdata", dmem_rdata,    g_resetn ? mem_rdata : 64'd0);
    if (!g_resetn) begin
      n_owner = 0;
      n_streak = 0;
    end else begin
      n_owner = (who != 0 && !mem_gnt) ? who : 0;
      n_streak = m_streak;
      if (!imem_req)                          n_streak = 0;
      else if (e_igt)                         n_streak = 0;
      else if (e_dgt && m_streak < STARVE)    n_streak = m_streak + 1;
    end
    @(posedge g_clk);
    m_owner = n_owner;
    m_streak = n_streak;
    #1;
  endtask

  task automatic idle();
    imem_req = 0; dmem_req = 0; dmem_wen = 0; mem_gnt = 0; mem_err = 0;
  endtask

  initial begin
    int exp_i4[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    g_resetn = 0;
    imem_req = 1; imem_addr = 64'h40; dmem_req = 1; dmem_addr = 64'h80;
    dmem_wen = 1; dmem_strb = 8'hFF; dmem_wdata = 64'h1234;
    mem_gnt = 1; mem_err = 1; mem_rdata = 64'hCAFE;
    @(posedge g_clk); #1;

    // reset holds every output at zero
    cyc();
    chk("rst_mem_req", 64'(o_mreq), 64'd0);
    chk("rst_rdata", o_irdata, 64'd0);
    g_resetn = 1; idle();
    cyc(); cyc();

    // single fetch, granted after two wait cycles
    imem_req = 1; imem_addr = 64'h1000;
    cyc();
    chk("f1_addr", o_addr, 64'h1000);
    chk("f1_wen", 64'(o_wen), 64'd0);
    chk("f1_igt_wait", 64'(o_igt), 64'd0);
    cyc();
    mem_gnt = 1; mem_rdata = 64'hDEAD_BEEF_0000_1111;
    cyc();
    chk("f1_igt", 64'(o_igt), 64'd1);
    chk("f1_dgt", 64'(o_dgt), 64'd0);
    chk("f1_rdata", o_irdata, 64'hDEAD_BEEF_0000_1111);
    idle(); cyc();

    // fetch locked, then a store appears and must wait for release
    imem_req = 1; imem_addr = 64'h3000;
    cyc();
    dmem_req = 1; dmem_wen = 1; dmem_addr = 64'h2008; dmem_strb = 8'hFF;
    dmem_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    cyc();
    chk("lock_addr", o_addr, 64'h3000);
    chk("lock_wen", 64'(o_wen), 64'd0);
    mem_gnt = 1;
    cyc();
    chk("lock_igt", 64'(o_igt), 64'd1);
    imem_req = 0; mem_gnt = 0;
    cyc();
    chk("st_addr", o_addr, 64'h2008);
    chk("st_wen", 64'(o_wen), 64'd1);
    chk("st_strb", 64'(o_strb), 64'hFF);
    chk("st_wdata", o_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
    mem_gnt = 1;
    cyc();
    chk("st_dgt", 64'(o_dgt), 64'd1);
    idle(); cyc(); cyc();

    // continuous contention, memory always ready
    imem_req = 1; dmem_req = 1; dmem_wen = 0; mem_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("starve_igt", 64'(o_igt), 64'(exp_i4[i]));
      chk("starve_dgt", 64'(o_dgt), 64'(exp_i4[i] == 0));
      chk("lim1_igt", 64'(o_u1_igt), 64'(i % 2));
    end
    idle(); cyc();

    // data read with error response
    dmem_req = 1; mem_gnt = 1; mem_err = 1;
    cyc();
    chk("err_dgt", 64'(o_dgt), 64'd1);
    chk("err_derr", 64'(o_derr), 64'd1);
    chk("err_ierr", 64'(o_ierr), 64'd0);
    idle(); cyc();

    // owner aborts, the waiting requester goes next
    imem_req = 1; imem_addr = 64'h5000;
    cyc();
    dmem_req = 1; dmem_addr = 64'h6000;
    cyc();
    imem_req = 0;
    cyc();
    chk("abort_mreq", 64'(o_mreq), 64'd0);
    mem_gnt = 1;
    cyc();
    chk("abort_next_addr", o_addr, 64'h6000);
    chk("abort_next_dgt", 64'(o_dgt), 64'd1);
    idle(); cyc();

    // reset while data owns with streak at 3
    imem_req = 1; dmem_req = 1; mem_gnt = 1;
    cyc(); cyc(); cyc();
    mem_gnt = 0;
    cyc();
    g_resetn = 0;
    cyc();
    chk("rst2_mreq", 64'(o_mreq), 64'd0);
    chk("rst2_dgt", 64'(o_dgt), 64'd0);
    g_resetn = 1; mem_gnt = 1;
    cyc();
    chk("rst2_winner_dgt", 64'(o_dgt), 64'd1);
    chk("rst2_winner_igt", 64'(o_igt), 64'd0);
    idle(); cyc();

    // randomized traffic with protocol-respecting requesters
    for (int i = 0; i < 600; i++) begin
      g_resetn = ($urandom_range(99) >= 2);
      if (!imem_req || e_igt || !g_resetn) begin
        imem_req = ($urandom_range(99) < 55);
        imem_addr = {$urandom, $urandom};
      end else if ($urandom_range(99) < 4) begin
        imem_req = 0;
      end
      if (!dmem_req || e_dgt || !g_resetn) begin
        dmem_req = ($urandom_range(99) < 60);
        dmem_addr = {$urandom, $urandom};
        dmem_wen = $urandom_range(1);
        dmem_strb = 8'($urandom);
        dmem_wdata = {$urandom, $urandom};
      end else if ($urandom_range(99) < 4) begin
        dmem_req = 0;
      end
      mem_gnt = ($urandom_range(99) < 55);
      mem_err = mem_gnt && ($urandom_range(7) == 0);
      mem_rdata = {$urandom, $urandom};
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Two-requester arbiter sharing one memory port between instruction fetch and the execute-stage LSU. It sits between the fetch and execute pipeline stages and the single core memory bus, forwarding one request at a time. It locks the chosen requester until its grant, so the memory sees stable request fields. Data accesses have priority, with a starvation limiter that guarantees fetch forward progress.

## Interface
Parameters:
- `MEM_ADDR_W`, 64: memory address width.
- `MEM_DATA_W`, 64: memory data width.
- `MEM_STRB_W`, 8: write strobe width (`MEM_DATA_W/8`).
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits; must be ≥1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `g_clk` in 1: global clock.
  - `g_resetn` in 1: global active-low synchronous reset.
- Fetch requester port:
  - `imem_req` in 1: fetch request.
  - `imem_addr` in MEM_ADDR_W: fetch address.
  - `imem_gnt` out 1: fetch response valid.
  - `imem_err` out 1: fetch response error.
  - `imem_rdata` out MEM_DATA_W: fetch read data.
- Data requester port:
  - `dmem_req` in 1: data request.
  - `dmem_addr` in MEM_ADDR_W: data address.
  - `dmem_wen` in 1: write enable.
  - `dmem_strb` in MEM_STRB_W: write strobe.
  - `dmem_wdata` in MEM_DATA_W: write data.
  - `dmem_gnt` out 1: data response valid.
  - `dmem_err` out 1: data response error.
  - `dmem_rdata` out MEM_DATA_W: data read data.
- Shared memory port:
  - `mem_req` out 1: memory request.
  - `mem_addr` out MEM_ADDR_W: request address.
  - `mem_wen` out 1: write enable.
  - `mem_strb` out MEM_STRB_W: write strobe.
  - `mem_wdata` out MEM_DATA_W: write data.
  - `mem_gnt` in 1: response valid; a transaction completes on `mem_req && mem_gnt`.
  - `mem_err` in 1: response error, valid with `mem_gnt`.
  - `mem_rdata` in MEM_DATA_W: read data, valid with `mem_gnt`.

## Operation
- Protocol:
  - A requester holds `req` and its fields stable until it sees its `gnt`.
  - `gnt`, `err` and `rdata` arrive in the same cycle; one transaction completes per grant cycle.
- Ownership register `owner`, states NONE, IMEM, DMEM; reset value NONE.
- Selection in NONE, combinational, same cycle:
  - Only one `req` high: that requester is selected.
  - Both high: DMEM is selected unless `streak == STARVE_LIMIT`, in which case IMEM is selected.
  - Neither high: no selection; `mem_req` = 0.
- Lock:
  - Selected requester's request is forwarded to `mem_*` at once.
  - If `mem_gnt` is low that cycle, `owner` takes the selected requester.
  - If `mem_gnt` is high, `owner` stays NONE and re-arbitration happens next cycle.
- Locked (IMEM or DMEM):
  - `mem_*` is driven solely from the owner, regardless of the other `req`.
  - Owner's `mem_gnt` with `mem_req` high: next `owner` is NONE.
  - Owner drops `req` before `gnt` (abort): `mem_req` falls the same cycle and next `owner` is NONE.
- Forwarding of fetch requests:
  - `mem_wen` = 0.
  - `mem_strb` = 0.
  - `mem_wdata` = 0.
- Response routing:
  - `mem_rdata` is broadcast to both `*_rdata`.
  - `imem_gnt`/`imem_err` = `mem_gnt`/`mem_err` gated by fetch selected or owning.
  - `dmem_gnt`/`dmem_err` are gated likewise for the data port.
  - The non-selected port sees `gnt` = 0 and `err` = 0.
- Starvation counter `streak` (range 0..STARVE_LIMIT, reset 0):
  - Increments, saturating, on each completed data transaction while `imem_req` is high.
  - Clears on a completed fetch transaction.
  - Clears in any cycle `imem_req` is low.
- Idle outputs with no selection: `mem_req`, `mem_wen`, `mem_strb`, `mem_addr`, `mem_wdata` = 0.

## Timing
- Request path: zero latency. `*_req` to `mem_req`, and `mem_gnt` to `*_gnt`, are combinational; no added pipeline.
- Back-to-back transactions: a new transaction may start the cycle after a grant, so one transaction per cycle is sustainable.
- Reset, including mid-transaction:
  - `owner` = NONE, `streak` = 0.
  - All outputs are 0 while `g_resetn` is low.
  - An in-flight memory transaction is abandoned; the memory is reset with the core.
- Simultaneous events:
  - Owner grant plus both requests high: no arbitration that cycle; the next cycle arbitrates in NONE using the updated `streak`.
  - `imem_req` rising while DMEM owns: no effect until release.
- Boundary with `STARVE_LIMIT=1`: fetch and data alternate under continuous contention.

## Test plan
- Single fetch, addr 0x1000, `mem_gnt` after 2 cycles:
  - `mem_addr` = 0x1000, `mem_wen` = 0 throughout.
  - `imem_gnt` pulses once with `mem_rdata`; `dmem_gnt` stays 0.
- Fetch locked, then `dmem_req` (store, addr 0x2008, strb 0xFF) raised a cycle later:
  - `mem_*` stays on the fetch until its grant.
  - Data request is issued the next cycle with the same fields.
- Both requesting continuously, `mem_gnt` tied high, STARVE_LIMIT=4:
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
- Data request with `mem_err`=1 on grant:
  - `dmem_err` = 1 and `dmem_gnt` = 1 for one cycle.
  - `imem_err` stays 0.
- Owner drops `req` mid-wait: `mem_req` = 0 that cycle; a pending other requester is selected next cycle.
- `g_resetn` low while DMEM owns and `streak`=3:
  - All outputs are 0.
  - After release, a simultaneous request is won by DMEM, since `streak` = 0.
